// File: rtl/obi_req_blocker.sv
// obi_req_blocker: sits on a core OBI manager port. Every accepted request is
// looked up by block address and held while the controller stalls, then
// forwarded with its address remapped into an SRAM slot.
// Optional feature macro: REQ_BLOCKER_WINDOW_EN. When defined, only requests
// inside [WindowBase, WindowBase+WindowSize) are looked up and remapped;
// others bypass the lookup and go out unmodified.
//
// state  | meaning
// IDLE   | waiting for a core request, grants if in-flight budget allows
// LOOKUP | first lookup cycle, valid_o high
// STALL  | controller holds block_i high, valid_o stays high
// ISSUE  | downstream req held until downstream gnt

package obi_req_blocker_pkg;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t SbrObiCfg = '{AddrWidth: 32, DataWidth: 32, IdWidth: 4};
    localparam int unsigned NUM_SRAM_ADDRESSES = 8;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } sbr_obi_a_chan_t;

    typedef struct packed {
        sbr_obi_a_chan_t a;
        logic            req;
    } sbr_obi_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic        err;
    } sbr_obi_r_chan_t;

    typedef struct packed {
        sbr_obi_r_chan_t r;
        logic            gnt;
        logic            rvalid;
    } sbr_obi_rsp_t;

endpackage

module obi_req_blocker
    import obi_req_blocker_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg           = SbrObiCfg,
    parameter type         obi_req_t        = sbr_obi_req_t,
    parameter type         obi_rsp_t        = sbr_obi_rsp_t,
    parameter int unsigned NumSramAddresses = NUM_SRAM_ADDRESSES,
    parameter logic [31:0] SramBaseAddr     = 32'h1000_0000,
    parameter int unsigned NumMaxTrans      = 2,
    parameter logic [31:0] WindowBase       = 32'h2000_0000,
    parameter logic [31:0] WindowSize       = 32'h0020_0000,
    localparam int unsigned IdxW            = $clog2(NumSramAddresses)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  obi_req_t        sbr_obi_req_i,
    output obi_rsp_t        sbr_obi_rsp_o,
    output obi_req_t        mgr_obi_req_o,
    input  obi_rsp_t        mgr_obi_rsp_i,
    output logic [20:0]     req_addr_o,
    output logic            valid_o,
    input  logic [IdxW-1:0] sram_addr_idx_i,
    input  logic            block_i,
    output logic            drained_o
);

    localparam int unsigned AW   = ObiCfg.AddrWidth;
    localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

    // The remap arithmetic and window compare assume a 32-bit address, and a
    // window that wraps past 2^32 would make the offset compare meaningless.
    if (AW != 32) begin : g_chk_aw
        $error("obi_req_blocker expects a 32-bit OBI address");
    end
    if ((WindowSize == 32'h0) || ((WindowBase + WindowSize) < WindowBase)) begin : g_chk_win
        $error("obi_req_blocker swap window is empty or wraps");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_STALL  = 2'd2,
        S_ISSUE  = 2'd3
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    obi_req_t          r_req;
    logic [IdxW-1:0]   r_idx;
    logic [CntW-1:0]   r_inflight;
    logic              w_sbr_gnt;
    logic              w_lookup;
    logic              w_inc;
    logic              w_dec;
    logic [31:0]       w_remap_addr;

`ifdef REQ_BLOCKER_WINDOW_EN
    logic              r_bypass;
    logic [31:0]       w_win_off;
    logic              w_in_window;

    assign w_win_off   = sbr_obi_req_i.a.addr - WindowBase;
    assign w_in_window = (w_win_off < WindowSize);
`endif

    // Grant is forced low while in reset so a core holding req never sees a
    // grant that the reset is about to discard.
    assign w_sbr_gnt = rst_ni && (r_state == S_IDLE) && sbr_obi_req_i.req
                       && (r_inflight < CntW'(NumMaxTrans));
    assign w_lookup  = (r_state == S_LOOKUP) || (r_state == S_STALL);
    assign w_inc     = mgr_obi_req_o.req && mgr_obi_rsp_i.gnt;
    // A response with nothing outstanding (e.g. one that survived a reset)
    // is dropped rather than forwarded.
    assign w_dec     = mgr_obi_rsp_i.rvalid && (r_inflight != '0);
    assign w_remap_addr = SramBaseAddr + AW'({r_idx, r_req.a.addr[10:0]});

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; block_i is deliberately not looked at in ISSUE since
    // an asserted OBI req may not be retracted.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_sbr_gnt) begin
`ifdef REQ_BLOCKER_WINDOW_EN
                    w_state_next = w_in_window ? S_LOOKUP : S_ISSUE;
`else
                    w_state_next = S_LOOKUP;
`endif
                end
            end
            S_LOOKUP, S_STALL: w_state_next = block_i ? S_STALL : S_ISSUE;
            S_ISSUE:  if (mgr_obi_rsp_i.gnt) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Latch the a-channel on grant and the slot index when the stall lifts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req <= '0;
            r_idx <= '0;
`ifdef REQ_BLOCKER_WINDOW_EN
            r_bypass <= 1'b0;
`endif
        end else begin
            if (w_sbr_gnt) begin
                r_req <= sbr_obi_req_i;
`ifdef REQ_BLOCKER_WINDOW_EN
                r_bypass <= !w_in_window;
`endif
            end
            if (w_lookup && !block_i) begin
                r_idx <= sram_addr_idx_i;
            end
        end
    end

    // Outstanding downstream transaction count, saturating at both ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_inflight <= '0;
        end else begin
            case ({w_inc, w_dec})
                2'b10: if (r_inflight < CntW'(NumMaxTrans)) r_inflight <= r_inflight + CntW'(1);
                2'b01: r_inflight <= r_inflight - CntW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Output logic: downstream request, core response and lookup handshake.
    always_comb begin
        mgr_obi_req_o = '0;
        if (r_state == S_ISSUE) begin
            mgr_obi_req_o        = r_req;
            mgr_obi_req_o.req    = 1'b1;
            mgr_obi_req_o.a.addr = w_remap_addr;
`ifdef REQ_BLOCKER_WINDOW_EN
            if (r_bypass) mgr_obi_req_o.a.addr = r_req.a.addr;
`endif
        end
        sbr_obi_rsp_o     = '0;
        sbr_obi_rsp_o.gnt = w_sbr_gnt;
        if (w_dec) begin
            sbr_obi_rsp_o.rvalid = 1'b1;
            sbr_obi_rsp_o.r      = mgr_obi_rsp_i.r;
        end
        valid_o    = w_lookup;
        req_addr_o = r_req.a.addr[31:11];
        drained_o  = (r_inflight == '0) && (r_state != S_ISSUE);
    end

    // A response with nothing in flight means the downstream broke protocol.
    a_no_spurious_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(mgr_obi_rsp_i.rvalid && (r_inflight == '0)));

endmodule

// File: tb/tb_obi_req_blocker.sv
// Directed bench for obi_req_blocker: expected downstream requests and core
// responses are queued when stimulus is driven and checked when they appear.
module tb_obi_req_blocker;
    import obi_req_blocker_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [3:0]  aid;
    } exp_a_t;

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  rid;
    } exp_r_t;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    sbr_obi_req_t sbr_obi_req_i;
    sbr_obi_rsp_t sbr_obi_rsp_o;
    sbr_obi_req_t mgr_obi_req_o;
    sbr_obi_rsp_t mgr_obi_rsp_i;
    logic [20:0]  req_addr_o;
    logic         valid_o;
    logic [2:0]   sram_addr_idx_i;
    logic         block_i;
    logic         drained_o;

    int n_cmp;
    int n_err;
    exp_a_t sb_a[$];
    exp_r_t sb_r[$];

    obi_req_blocker dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .sbr_obi_req_i   (sbr_obi_req_i),
        .sbr_obi_rsp_o   (sbr_obi_rsp_o),
        .mgr_obi_req_o   (mgr_obi_req_o),
        .mgr_obi_rsp_i   (mgr_obi_rsp_i),
        .req_addr_o      (req_addr_o),
        .valid_o         (valid_o),
        .sram_addr_idx_i (sram_addr_idx_i),
        .block_i         (block_i),
        .drained_o       (drained_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] remap(input logic [31:0] addr, input logic [2:0] idx);
        logic [13:0] slot;
        slot = {idx, addr[10:0]};
        return 32'h1000_0000 + {18'h0, slot};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge and clear one-shot inputs.
    task automatic cyc();
        @(posedge clk_i);
        #2;
        sbr_obi_req_i.req    = 1'b0;
        mgr_obi_rsp_i.gnt    = 1'b0;
        mgr_obi_rsp_i.rvalid = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input logic [3:0] aid);
        sbr_obi_req_i.req     = 1'b1;
        sbr_obi_req_i.a.addr  = addr;
        sbr_obi_req_i.a.we    = we;
        sbr_obi_req_i.a.be    = be;
        sbr_obi_req_i.a.wdata = wdata;
        sbr_obi_req_i.a.aid   = aid;
    endtask

    task automatic push_a(input logic [31:0] mgr_addr);
        exp_a_t e;
        e.addr  = mgr_addr;
        e.we    = sbr_obi_req_i.a.we;
        e.be    = sbr_obi_req_i.a.be;
        e.wdata = sbr_obi_req_i.a.wdata;
        e.aid   = sbr_obi_req_i.a.aid;
        sb_a.push_back(e);
    endtask

    task automatic send_rsp(input logic [31:0] rdata, input logic [3:0] rid);
        exp_r_t e;
        mgr_obi_rsp_i.rvalid  = 1'b1;
        mgr_obi_rsp_i.r.rdata = rdata;
        mgr_obi_rsp_i.r.rid   = rid;
        mgr_obi_rsp_i.r.err   = 1'b0;
        e.rdata = rdata;
        e.rid   = rid;
        sb_r.push_back(e);
    endtask

    task automatic check_issue(input string tag);
        exp_a_t e;
        if (sb_a.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed downstream request expected none queued", tag);
        end else begin
            e = sb_a.pop_front();
            chk({tag, "_req"},   64'(mgr_obi_req_o.req), 64'(1'b1));
            chk({tag, "_addr"},  64'(mgr_obi_req_o.a.addr), 64'(e.addr));
            chk({tag, "_we"},    64'(mgr_obi_req_o.a.we), 64'(e.we));
            chk({tag, "_be"},    64'(mgr_obi_req_o.a.be), 64'(e.be));
            chk({tag, "_wdata"}, 64'(mgr_obi_req_o.a.wdata), 64'(e.wdata));
            chk({tag, "_aid"},   64'(mgr_obi_req_o.a.aid), 64'(e.aid));
        end
    endtask

    task automatic check_rsp(input string tag);
        exp_r_t e;
        if (sb_r.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed response check expected queued response", tag);
        end else begin
            e = sb_r.pop_front();
            chk({tag, "_rvalid"}, 64'(sbr_obi_rsp_o.rvalid), 64'(1'b1));
            chk({tag, "_rdata"},  64'(sbr_obi_rsp_o.r.rdata), 64'(e.rdata));
            chk({tag, "_rid"},    64'(sbr_obi_rsp_o.r.rid), 64'(e.rid));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected end of sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_ni          = 1'b0;
        sbr_obi_req_i   = '0;
        mgr_obi_rsp_i   = '0;
        sram_addr_idx_i = '0;
        block_i         = 1'b0;

        // Reset values, with a core request pending to show no grant leaks out.
        sbr_obi_req_i.req = 1'b1;
        #3;
        chk("rst_gnt",      64'(sbr_obi_rsp_o.gnt), 64'(1'b0));
        chk("rst_rsp_zero", 64'(sbr_obi_rsp_o == '0), 64'(1'b1));
        chk("rst_mgr_zero", 64'(mgr_obi_req_o == '0), 64'(1'b1));
        chk("rst_valid",    64'(valid_o), 64'(1'b0));
        chk("rst_req_addr", 64'(req_addr_o), 64'(0));
        chk("rst_drained",  64'(drained_o), 64'(1'b1));
        cyc();
        cyc();
        rst_ni = 1'b1;

        // Single read, no stall, idx 3.
        cyc();
        set_req(32'h2000_0844, 1'b0, 4'hF, 32'h0, 4'h1);
        push_a(32'h1000_1844);
        settle();
        chk("t1_gnt",     64'(sbr_obi_rsp_o.gnt), 64'(1'b1));
        chk("t1_valid_c0", 64'(valid_o), 64'(1'b0));
        cyc();
        block_i = 1'b0;
        sram_addr_idx_i = 3'd3;
        settle();
        chk("t1_valid",    64'(valid_o), 64'(1'b1));
        chk("t1_req_addr", 64'(req_addr_o), 64'(21'h40001));
        chk("t1_no_mgr",   64'(mgr_obi_req_o.req), 64'(1'b0));
        chk("t1_no_gnt_lookup", 64'(sbr_obi_rsp_o.gnt), 64'(1'b0));
        cyc();
        sram_addr_idx_i = 3'd0;
        mgr_obi_rsp_i.gnt = 1'b1;
        settle();
        check_issue("t1_issue");
        chk("t1_valid_issue",   64'(valid_o), 64'(1'b0));
        chk("t1_drained_issue", 64'(drained_o), 64'(1'b0));
        cyc();
        send_rsp(32'hCAFE_BABE, 4'h1);
        settle();
        check_rsp("t1_rsp");
        chk("t1_mgr_idle",  64'(mgr_obi_req_o.req), 64'(1'b0));
        chk("t1_drained_inflight", 64'(drained_o), 64'(1'b0));
        cyc();
        settle();
        chk("t1_drained_end", 64'(drained_o), 64'(1'b1));

        // Write stalled for five cycles; idx at the falling edge of block_i wins.
        cyc();
        set_req(32'h2000_0A10, 1'b1, 4'hC, 32'h1234_5678, 4'h2);
        push_a(32'h1000_0A10);
        settle();
        chk("t2_gnt", 64'(sbr_obi_rsp_o.gnt), 64'(1'b1));
        for (int i = 0; i < 5; i++) begin
            cyc();
            block_i = 1'b1;
            sram_addr_idx_i = 3'd5;
            settle();
            chk("t2_valid_stall", 64'(valid_o), 64'(1'b1));
            chk("t2_no_mgr_stall", 64'(mgr_obi_req_o.req), 64'(1'b0));
        end
        cyc();
        block_i = 1'b0;
        sram_addr_idx_i = 3'd1;
        settle();
        chk("t2_valid_fall", 64'(valid_o), 64'(1'b1));
        chk("t2_no_mgr_fall", 64'(mgr_obi_req_o.req), 64'(1'b0));
        cyc();
        block_i = 1'b1;
        sram_addr_idx_i = 3'd6;
        mgr_obi_rsp_i.gnt = 1'b1;
        settle();
        check_issue("t2_issue");
        chk("t2_valid_issue", 64'(valid_o), 64'(1'b0));
        cyc();
        block_i = 1'b0;
        send_rsp(32'hA5A5_0001, 4'h2);
        settle();
        check_rsp("t2_rsp");
        cyc();
        settle();
        chk("t2_drained_end", 64'(drained_o), 64'(1'b1));

        // Two outstanding transactions exhaust the budget; third waits.
        cyc();
        set_req(32'h2000_1004, 1'b0, 4'hF, 32'h0, 4'h3);
        push_a(remap(32'h2000_1004, 3'd2));
        settle();
        chk("t3a_gnt", 64'(sbr_obi_rsp_o.gnt), 64'(1'b1));
        cyc();
        sram_addr_idx_i = 3'd2;
        settle();
        cyc();
        mgr_obi_rsp_i.gnt = 1'b1;
        settle();
        check_issue("t3a_issue");
        cyc();
        set_req(32'h2000_2008, 1'b0, 4'hF, 32'h0, 4'h4);
        push_a(remap(32'h2000_2008, 3'd4));
        settle();
        chk("t3b_gnt", 64'(sbr_obi_rsp_o.gnt), 64'(1'b1));
        chk("t3b_drained", 64'(drained_o), 64'(1'b0));
        cyc();
        sram_addr_idx_i = 3'd4;
        settle();
        cyc();
        mgr_obi_rsp_i.gnt = 1'b1;
        settle();
        check_issue("t3b_issue");
        for (int i = 0; i < 3; i++) begin
            cyc();
            set_req(32'h2000_300C, 1'b1, 4'h3, 32'hDEAD_0003, 4'h5);
            settle();
            chk("t3c_blocked_gnt", 64'(sbr_obi_rsp_o.gnt), 64'(1'b0));
            chk("t3c_drained", 64'(drained_o), 64'(1'b0));
        end
        cyc();
        set_req(32'h2000_300C, 1'b1, 4'h3, 32'hDEAD_0003, 4'h5);
        send_rsp(32'h1111_0000, 4'h3);
        settle();
        check_rsp("t3a_rsp");
        chk("t3c_gnt_on_rvalid", 64'(sbr_obi_rsp_o.gnt), 64'(1'b0));
        cyc();
        set_req(32'h2000_300C, 1'b1, 4'h3, 32'hDEAD_0003, 4'h5);
        push_a(remap(32'h2000_300C, 3'd5));
        settle();
        chk("t3c_gnt", 64'(sbr_obi_rsp_o.gnt), 64'(1'b1));
        cyc();
        sram_addr_idx_i = 3'd5;
        settle();
        chk("t3c_req_addr", 64'(req_addr_o), 64'(21'h40006));
        cyc();
        mgr_obi_rsp_i.gnt = 1'b1;
        send_rsp(32'h2222_0000, 4'h4);
        settle();
        check_issue("t3c_issue");
        check_rsp("t3b_rsp");
        cyc();
        settle();
        chk("t3_same_cycle_drained", 64'(drained_o), 64'(1'b0));
        cyc();
        send_rsp(32'h3333_0000, 4'h5);
        settle();
        check_rsp("t3c_rsp");
        chk("t3_last_rvalid_drained", 64'(drained_o), 64'(1'b0));
        cyc();
        settle();
        chk("t3_drained_end", 64'(drained_o), 64'(1'b1));

        // Reset asserted during STALL with one transaction still in flight.
        cyc();
        set_req(32'h2000_4000, 1'b0, 4'hF, 32'h0, 4'h6);
        push_a(remap(32'h2000_4000, 3'd0));
        settle();
        cyc();
        sram_addr_idx_i = 3'd0;
        settle();
        cyc();
        mgr_obi_rsp_i.gnt = 1'b1;
        settle();
        check_issue("t4d_issue");
        cyc();
        set_req(32'h2000_5000, 1'b0, 4'hF, 32'h0, 4'h7);
        settle();
        chk("t4e_gnt", 64'(sbr_obi_rsp_o.gnt), 64'(1'b1));
        cyc();
        block_i = 1'b1;
        settle();
        cyc();
        settle();
        chk("t4_valid_stall", 64'(valid_o), 64'(1'b1));
        chk("t4_drained_pre", 64'(drained_o), 64'(1'b0));
        sbr_obi_req_i.req = 1'b1;
        rst_ni = 1'b0;
        settle();
        chk("t4_rst_valid",   64'(valid_o), 64'(1'b0));
        chk("t4_rst_mgr_req", 64'(mgr_obi_req_o.req), 64'(1'b0));
        chk("t4_rst_gnt",     64'(sbr_obi_rsp_o.gnt), 64'(1'b0));
        chk("t4_rst_drained", 64'(drained_o), 64'(1'b1));
        cyc();
        rst_ni = 1'b1;
        block_i = 1'b0;
        settle();
        chk("t4_post_valid",   64'(valid_o), 64'(1'b0));
        chk("t4_post_drained", 64'(drained_o), 64'(1'b1));
        cyc();
        set_req(32'h2000_6040, 1'b1, 4'h1, 32'h0000_00AB, 4'h8);
        push_a(remap(32'h2000_6040, 3'd7));
        settle();
        chk("t4_post_gnt", 64'(sbr_obi_rsp_o.gnt), 64'(1'b1));
        cyc();
        sram_addr_idx_i = 3'd7;
        settle();
        cyc();
        mgr_obi_rsp_i.gnt = 1'b1;
        settle();
        check_issue("t4_post_issue");
        cyc();
        send_rsp(32'h4444_0000, 4'h8);
        settle();
        check_rsp("t4_post_rsp");
        cyc();
        settle();
        chk("t4_drained_end", 64'(drained_o), 64'(1'b1));

`ifdef REQ_BLOCKER_WINDOW_EN
        // Out-of-window request bypasses lookup and keeps its address.
        cyc();
        set_req(32'h0300_0000, 1'b0, 4'hF, 32'h0, 4'h9);
        push_a(32'h0300_0000);
        settle();
        chk("t5_gnt",   64'(sbr_obi_rsp_o.gnt), 64'(1'b1));
        chk("t5_valid", 64'(valid_o), 64'(1'b0));
        cyc();
        sram_addr_idx_i = 3'd2;
        mgr_obi_rsp_i.gnt = 1'b1;
        settle();
        check_issue("t5_issue");
        chk("t5_valid_issue", 64'(valid_o), 64'(1'b0));
        cyc();
        send_rsp(32'h5555_0000, 4'h9);
        settle();
        check_rsp("t5_rsp");
`endif

        chk("sb_a_empty", 64'(sb_a.size()), 64'(0));
        chk("sb_r_empty", 64'(sb_r.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
